// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator between the MEM
// stage and a word-wide data memory. Performs big-endian sub-word load
// extraction (sign/zero extend), turns SB/SH into read-modify-write, and
// rejects misaligned, illegal-size or out-of-range requests without touching
// memory.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   ReqValid/ReqReady      request handshake (ready only in IDLE)
//   ReqWrite, ReqOp,       request: store flag, {unsigned, size[1:0]},
//   ReqAddr, ReqWData      byte address, store data (low 8/16/32 bits)
//   RespValid, RespError,  one-cycle response pulse, reject flag,
//   RespData               load result (0 unless a successful load)
//   MemRead, MemWrite,     memory strobes, word-aligned address,
//   Address, WriteData,    write word,
//   ReadData               read word registered by memory on MemRead edge

module load_store_unit #(
    parameter int unsigned MEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [2:0]  ReqOp,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic        RespError,
    output logic [31:0] RespData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned OPW = 3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [OPW-1:0] op_q;
    logic           write_q;
    logic           err_q;

    logic           accept_c;
    logic           req_err_c;
    logic [7:0]     byte_c;
    logic [15:0]    half_c;
    logic [DW-1:0]  load_ext_c;
    logic [DW-1:0]  merge_c;

    // Ready is withheld while reset is asserted so nothing is accepted then.
    assign ReqReady = (state == IDLE) && !reset;
    assign accept_c = ReqValid && ReqReady;

    // Request classification: illegal size, misalignment, or word index past the end.
    always_comb begin
        req_err_c = 1'b0;
        case (ReqOp[1:0])
            SZ_BYTE: req_err_c = 1'b0;
            SZ_HALF: req_err_c = ReqAddr[0];
            SZ_WORD: req_err_c = |ReqAddr[1:0];
            default: req_err_c = 1'b1;
        endcase
        if ({2'b00, ReqAddr[31:2]} >= 32'(MEM_WORDS)) begin
            req_err_c = 1'b1;
        end
    end

    // Request latch, loaded only on an accepted handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept_c) begin
            addr_q  <= ReqAddr;
            wdata_q <= ReqWData;
            op_q    <= ReqOp;
            write_q <= ReqWrite;
            err_q   <= req_err_c;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Big-endian lane select from the word returned by memory.
    always_comb begin
        byte_c = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_c = ReadData[31:24];
            2'd1:    byte_c = ReadData[23:16];
            2'd2:    byte_c = ReadData[15:8];
            default: byte_c = ReadData[7:0];
        endcase
        half_c = addr_q[1] ? ReadData[15:0] : ReadData[31:16];
    end

    // Load result: extracted field, sign-extended unless op bit 2 requests zero-extension.
    always_comb begin
        load_ext_c = ReadData;
        case (op_q[1:0])
            SZ_BYTE: load_ext_c = op_q[2] ? {24'h000000, byte_c}
                                          : {{24{byte_c[7]}}, byte_c};
            SZ_HALF: load_ext_c = op_q[2] ? {16'h0000, half_c}
                                          : {{16{half_c[15]}}, half_c};
            default: load_ext_c = ReadData;
        endcase
    end

    // Read-modify-write merge: replace the addressed lane(s) of the old word.
    always_comb begin
        merge_c = ReadData;
        if (op_q[1:0] == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merge_c = {wdata_q[7:0], ReadData[23:0]};
                2'd1:    merge_c = {ReadData[31:24], wdata_q[7:0], ReadData[15:0]};
                2'd2:    merge_c = {ReadData[31:16], wdata_q[7:0], ReadData[7:0]};
                default: merge_c = {ReadData[31:8], wdata_q[7:0]};
            endcase
        end else begin
            merge_c = addr_q[1] ? {ReadData[31:16], wdata_q[15:0]}
                                : {wdata_q[15:0], ReadData[15:0]};
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_next = state;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = '0;
        WriteData  = '0;
        RespValid  = 1'b0;
        RespError  = 1'b0;
        RespData   = '0;

        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (req_err_c) begin
                        state_next = RESP;
                    end else if (!ReqWrite) begin
                        state_next = LOAD;
                    end else if (ReqOp[1:0] == SZ_WORD) begin
                        state_next = STORE;
                    end else begin
                        state_next = RMW_RD;
                    end
                end
            end
            LOAD: begin
                MemRead    = 1'b1;
                Address    = {addr_q[31:2], 2'b00};
                state_next = RESP;
            end
            STORE: begin
                MemWrite   = 1'b1;
                Address    = {addr_q[31:2], 2'b00};
                WriteData  = wdata_q;
                state_next = RESP;
            end
            RMW_RD: begin
                MemRead    = 1'b1;
                Address    = {addr_q[31:2], 2'b00};
                state_next = RMW_WR;
            end
            RMW_WR: begin
                MemWrite   = 1'b1;
                Address    = {addr_q[31:2], 2'b00};
                WriteData  = merge_c;
                state_next = RESP;
            end
            RESP: begin
                RespValid  = 1'b1;
                RespError  = err_q;
                // ReadData here is the word fetched by the preceding LOAD cycle.
                if (!err_q && !write_q) begin
                    RespData = load_ext_c;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
